// File: rtl/io_in_reg_ctrl_pkg.sv
// Shared types for the IO input-register bank controller: FSM state encoding
// and the clear-counter width helper.
package io_in_reg_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_CLEAR   = 2'd2,
    ST_RELEASE = 2'd3
  } ctrl_state_e;

  // Counter holds values CLR_CYCLES-1 down to 0; never narrower than one bit.
  function automatic int cnt_width(input int clr_cycles);
    return (clr_cycles <= 1) ? 1 : $clog2(clr_cycles);
  endfunction

endpackage

// File: rtl/io_in_reg_cfg_bank.sv
// Per-pad ISEL/FIXHOLD storage with address decode and out-of-range error pulse.
module io_in_reg_cfg_bank #(
  parameter int NUM_PADS = 8,
  parameter int ADDR_W   = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                isel_i,
  input  logic                fixhold_i,
  output logic [NUM_PADS-1:0] isel_o,
  output logic [NUM_PADS-1:0] fixhold_o,
  output logic                err_o
);

  logic [NUM_PADS-1:0] sel;
  logic                in_range;
  logic [NUM_PADS-1:0] isel_q;
  logic [NUM_PADS-1:0] fixhold_q;
  logic                err_q;

  // Explicit compare per pad keeps the decode safe when ADDR_W exceeds the pad index width.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      sel[i] = ({1'b0, addr_i} == (ADDR_W+1)'(i));
    end
  end

  assign in_range = |sel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      isel_q    <= '1;
      fixhold_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= we_i & ~in_range;
      for (int i = 0; i < NUM_PADS; i++) begin
        if (we_i && sel[i]) begin
          isel_q[i]    <= isel_i;
          fixhold_q[i] <= fixhold_i;
        end
      end
    end
  end

  assign isel_o    = isel_q;
  assign fixhold_o = fixhold_q;
  assign err_o     = err_q;

endmodule

// File: rtl/io_in_reg_ctrl.sv
// Bank controller for NUM_PADS input-register IO cells: config, clear sequencing, IQZ snapshot.
// Optional build macro IOREG_CLR_ON_CFG_EN: accepted in-range config writes also clear that pad.
module io_in_reg_ctrl
  import io_in_reg_ctrl_pkg::*;
#(
  parameter int NUM_PADS   = 8,
  parameter int CLR_CYCLES = 4,
  parameter int ADDR_W     = 5
) (
  input  logic                IQC,
  input  logic                QRT_N,
  input  logic                CFG_WE,
  input  logic [ADDR_W-1:0]   CFG_ADDR,
  input  logic                CFG_ISEL,
  input  logic                CFG_FIXHOLD,
  output logic                CFG_RDY,
  output logic                CFG_ERR,
  input  logic                CLR_REQ,
  input  logic [NUM_PADS-1:0] CLR_MASK,
  output logic                CLR_DONE,
  output logic [NUM_PADS-1:0] ISEL_O,
  output logic [NUM_PADS-1:0] FIXHOLD_O,
  output logic [NUM_PADS-1:0] QRT_O,
  output logic                CAPT_EN,
  input  logic [NUM_PADS-1:0] IQZ_I,
  input  logic                RD_REQ,
  output logic                RD_ACK,
  output logic [NUM_PADS-1:0] RD_DATA,
  output logic [STATE_W-1:0]  DBG_STATE
);

  localparam int               CNT_W    = cnt_width(CLR_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CLR_CYCLES - 1);

  ctrl_state_e         state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_PADS-1:0] mask_q;
  logic [NUM_PADS-1:0] qrt_q;
  logic                capt_q;
  logic                done_q;
  logic                rd_pend_q;
  logic                rd_ack_q;
  logic [NUM_PADS-1:0] rd_data_q;

  logic                cfg_rdy;
  logic                cfg_acc;
  logic                clr_acc;
  logic                clr_start_d;
  logic [NUM_PADS-1:0] clr_mask_d;

  // Handshake: CFG_WE and CLR_REQ are strobes taken on the edge that ends a cycle
  // with CFG_RDY=1 (IDLE only); otherwise they are dropped. RD_REQ is never dropped:
  // it is served in IDLE or held as one merged pending request until IDLE.
  assign cfg_rdy = (state_q == ST_IDLE);
  assign cfg_acc = CFG_WE & cfg_rdy;
  assign clr_acc = CLR_REQ & cfg_rdy;

`ifdef IOREG_CLR_ON_CFG_EN
  logic [NUM_PADS-1:0] cfg_onehot;
  logic                auto_clr;

  always_comb begin
    cfg_onehot = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      cfg_onehot[i] = ({1'b0, CFG_ADDR} == (ADDR_W+1)'(i));
    end
  end

  assign auto_clr    = cfg_acc & (|cfg_onehot);
  assign clr_start_d = clr_acc | auto_clr;
  assign clr_mask_d  = (clr_acc ? CLR_MASK : '0) | (auto_clr ? cfg_onehot : '0);
`else
  assign clr_start_d = clr_acc;
  assign clr_mask_d  = CLR_MASK;
`endif

  io_in_reg_cfg_bank #(
    .NUM_PADS (NUM_PADS),
    .ADDR_W   (ADDR_W)
  ) u_cfg_bank (
    .clk_i     (IQC),
    .rst_ni    (QRT_N),
    .we_i      (cfg_acc),
    .addr_i    (CFG_ADDR),
    .isel_i    (CFG_ISEL),
    .fixhold_i (CFG_FIXHOLD),
    .isel_o    (ISEL_O),
    .fixhold_o (FIXHOLD_O),
    .err_o     (CFG_ERR)
  );

  // Outputs are loaded together with the state so each matches the state it is in.
  always_ff @(posedge IQC or negedge QRT_N) begin
    if (!QRT_N) begin
      state_q <= ST_CLEAR;
      cnt_q   <= CNT_INIT;
      mask_q  <= '1;
      qrt_q   <= '1;
      capt_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clr_start_d) begin
            state_q <= ST_QUIESCE;
            mask_q  <= clr_mask_d;
            capt_q  <= 1'b0;
          end
        end
        ST_QUIESCE: begin
          state_q <= ST_CLEAR;
          cnt_q   <= CNT_INIT;
          qrt_q   <= mask_q;
        end
        ST_CLEAR: begin
          if (cnt_q == '0) begin
            state_q <= ST_RELEASE;
            qrt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
          capt_q  <= 1'b1;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= CNT_INIT;
          mask_q  <= '1;
          qrt_q   <= '1;
          capt_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge IQC or negedge QRT_N) begin
    if (!QRT_N) begin
      rd_pend_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (RD_REQ || rd_pend_q) begin
          rd_data_q <= IQZ_I;
          rd_ack_q  <= 1'b1;
          rd_pend_q <= 1'b0;
        end
      end else if (RD_REQ) begin
        rd_pend_q <= 1'b1;
      end
    end
  end

  assign CFG_RDY   = cfg_rdy;
  assign CLR_DONE  = done_q;
  assign QRT_O     = qrt_q;
  assign CAPT_EN   = capt_q;
  assign RD_ACK    = rd_ack_q;
  assign RD_DATA   = rd_data_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_io_in_reg_ctrl.sv
// Self-checking bench for io_in_reg_ctrl (default build, NUM_PADS=8, CLR_CYCLES=4).
module tb_io_in_reg_ctrl;
  import io_in_reg_ctrl_pkg::*;

  localparam int NP = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          QRT_N;
  logic          CFG_WE;
  logic [AW-1:0] CFG_ADDR;
  logic          CFG_ISEL;
  logic          CFG_FIXHOLD;
  logic          CFG_RDY;
  logic          CFG_ERR;
  logic          CLR_REQ;
  logic [NP-1:0] CLR_MASK;
  logic          CLR_DONE;
  logic [NP-1:0] ISEL_O;
  logic [NP-1:0] FIXHOLD_O;
  logic [NP-1:0] QRT_O;
  logic          CAPT_EN;
  logic [NP-1:0] IQZ_I;
  logic          RD_REQ;
  logic          RD_ACK;
  logic [NP-1:0] RD_DATA;
  logic [STATE_W-1:0] DBG_STATE;

  int errors = 0;
  int checks = 0;
  logic [NP-1:0] exp_q[$];
  logic [NP-1:0] mon_e;
  logic          prev_ack = 1'b0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          isel;
    logic          fix;
    logic [NP-1:0] exp_isel;
    logic [NP-1:0] exp_fix;
    logic          exp_err;
  } cfg_vec_t;

  cfg_vec_t tbl[8];

  io_in_reg_ctrl #(.NUM_PADS(NP), .CLR_CYCLES(4), .ADDR_W(AW)) dut (
    .IQC(clk), .QRT_N(QRT_N),
    .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_ISEL(CFG_ISEL), .CFG_FIXHOLD(CFG_FIXHOLD),
    .CFG_RDY(CFG_RDY), .CFG_ERR(CFG_ERR),
    .CLR_REQ(CLR_REQ), .CLR_MASK(CLR_MASK), .CLR_DONE(CLR_DONE),
    .ISEL_O(ISEL_O), .FIXHOLD_O(FIXHOLD_O), .QRT_O(QRT_O), .CAPT_EN(CAPT_EN),
    .IQZ_I(IQZ_I), .RD_REQ(RD_REQ), .RD_ACK(RD_ACK), .RD_DATA(RD_DATA),
    .DBG_STATE(DBG_STATE)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached before summary, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input int act, input int req);
    checks++;
    errors++;
    $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_edges, output int edges);
    bit seen;
    seen  = 1'b0;
    edges = -1;
    for (int k = 1; k <= max_edges && !seen; k++) begin
      tick();
      if (CLR_DONE) begin
        seen  = 1'b1;
        edges = k;
      end
    end
    if (!seen) note_fail("clr_done_timeout", edges, max_edges);
  endtask

  // Scoreboard: each RD_ACK pops one expected snapshot.
  always @(negedge clk) begin
    if (!QRT_N) begin
      prev_ack = 1'b0;
    end else begin
      if (RD_ACK) begin
        if (prev_ack) note_fail("rd_ack_back_to_back", 1, 0);
        if (exp_q.size() == 0) begin
          note_fail("rd_ack_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_data", 32'(RD_DATA), 32'(mon_e));
        end
      end
      prev_ack = RD_ACK;
    end
  end

  logic [NP-1:0] exp_isel;
  logic [NP-1:0] exp_fix;
  logic [NP-1:0] qrt_exp[7];
  logic          capt_exp[7];
  logic          done_exp[7];
  int            edges;

  initial begin
    tbl[0] = '{5'd3,  1'b0, 1'b1, 8'hF7, 8'h08, 1'b0};
    tbl[1] = '{5'd9,  1'b0, 1'b1, 8'hF7, 8'h08, 1'b1};
    tbl[2] = '{5'd0,  1'b0, 1'b0, 8'hF6, 8'h08, 1'b0};
    tbl[3] = '{5'd7,  1'b1, 1'b1, 8'hF6, 8'h88, 1'b0};
    tbl[4] = '{5'd3,  1'b1, 1'b0, 8'hFE, 8'h80, 1'b0};
    tbl[5] = '{5'd31, 1'b0, 1'b1, 8'hFE, 8'h80, 1'b1};
    tbl[6] = '{5'd8,  1'b0, 1'b1, 8'hFE, 8'h80, 1'b1};
    tbl[7] = '{5'd7,  1'b0, 1'b0, 8'h7E, 8'h00, 1'b0};

    qrt_exp  = '{8'h00, 8'h05, 8'h05, 8'h05, 8'h05, 8'h00, 8'h00};
    capt_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    done_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    QRT_N = 1'b0; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_ISEL = 1'b0; CFG_FIXHOLD = 1'b0;
    CLR_REQ = 1'b0; CLR_MASK = '0; IQZ_I = '0; RD_REQ = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_isel", 32'(ISEL_O), 'hFF);
    check("rst_fix", 32'(FIXHOLD_O), 'h00);
    check("rst_qrt", 32'(QRT_O), 'hFF);
    check("rst_capt", 32'(CAPT_EN), 0);
    check("rst_rdy", 32'(CFG_RDY), 0);
    check("rst_err", 32'(CFG_ERR), 0);
    check("rst_done", 32'(CLR_DONE), 0);
    check("rst_ack", 32'(RD_ACK), 0);
    check("rst_rd_data", 32'(RD_DATA), 0);
    check("rst_state", 32'(DBG_STATE), 32'(ST_CLEAR));

    // Power-on clear
    QRT_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("por_qrt_%0d", k), 32'(QRT_O), 'hFF);
      check($sformatf("por_capt_%0d", k), 32'(CAPT_EN), 0);
      tick();
    end
    check("por_release_qrt", 32'(QRT_O), 'h00);
    check("por_release_capt", 32'(CAPT_EN), 0);
    check("por_release_done", 32'(CLR_DONE), 0);
    tick();
    check("por_done", 32'(CLR_DONE), 1);
    check("por_capt", 32'(CAPT_EN), 1);
    check("por_rdy", 32'(CFG_RDY), 1);
    check("por_isel", 32'(ISEL_O), 'hFF);
    check("por_state", 32'(DBG_STATE), 32'(ST_IDLE));
    tick();
    check("por_done_pulse", 32'(CLR_DONE), 0);

    // Config writes from table
    for (int i = 0; i < 8; i++) begin
      CFG_WE = 1'b1; CFG_ADDR = tbl[i].addr; CFG_ISEL = tbl[i].isel; CFG_FIXHOLD = tbl[i].fix;
      tick();
      CFG_WE = 1'b0;
      check($sformatf("cfg%0d_isel", i), 32'(ISEL_O), 32'(tbl[i].exp_isel));
      check($sformatf("cfg%0d_fix", i), 32'(FIXHOLD_O), 32'(tbl[i].exp_fix));
      check($sformatf("cfg%0d_err", i), 32'(CFG_ERR), 32'(tbl[i].exp_err));
      tick();
      check($sformatf("cfg%0d_err_pulse", i), 32'(CFG_ERR), 0);
    end
    exp_isel = 8'h7E;
    exp_fix  = 8'h00;

    // Read in IDLE
    IQZ_I = 8'h3C; RD_REQ = 1'b1;
    exp_q.push_back(8'h3C);
    tick();
    RD_REQ = 1'b0; IQZ_I = 8'h11;
    check("rd_idle_ack", 32'(RD_ACK), 1);
    check("rd_idle_data", 32'(RD_DATA), 'h3C);
    tick();
    check("rd_idle_ack_pulse", 32'(RD_ACK), 0);

    // Masked clear; a CLR_REQ during CLEAR must be ignored
    CLR_REQ = 1'b1; CLR_MASK = 8'h05;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k == 0) begin
        CLR_REQ = 1'b0;
        check("mclr_quiesce_state", 32'(DBG_STATE), 32'(ST_QUIESCE));
      end
      if (k == 2) begin CLR_REQ = 1'b1; CLR_MASK = 8'hFF; end
      if (k == 3) CLR_REQ = 1'b0;
      check($sformatf("mclr_qrt_e%0d", k + 1), 32'(QRT_O), 32'(qrt_exp[k]));
      check($sformatf("mclr_capt_e%0d", k + 1), 32'(CAPT_EN), 32'(capt_exp[k]));
      check($sformatf("mclr_done_e%0d", k + 1), 32'(CLR_DONE), 32'(done_exp[k]));
    end
    tick();
    tick();
    check("mclr_ignored_state", 32'(DBG_STATE), 32'(ST_IDLE));
    check("mclr_ignored_capt", 32'(CAPT_EN), 1);

    // Read during clear: held pending, merged, served after CLR_DONE
    CLR_REQ = 1'b1; CLR_MASK = 8'hFF;
    tick();
    CLR_REQ = 1'b0; IQZ_I = 8'h5A;
    tick();
    RD_REQ = 1'b1;
    exp_q.push_back(8'hA5);
    tick();
    tick();
    RD_REQ = 1'b0;
    check("rdclr_no_early_ack", 32'(RD_ACK), 0);
    wait_done(10, edges);
    check("rdclr_done_edges", 32'(edges), 3);
    check("rdclr_ack_at_done", 32'(RD_ACK), 0);
    IQZ_I = 8'hA5;
    tick();
    check("rdclr_ack", 32'(RD_ACK), 1);
    check("rdclr_data", 32'(RD_DATA), 'hA5);
    tick();
    check("rdclr_single_ack", 32'(RD_ACK), 0);

    // Simultaneous write + clear in IDLE; writes during CLEAR dropped
    CFG_WE = 1'b1; CFG_ADDR = 5'd1; CFG_ISEL = 1'b0; CFG_FIXHOLD = 1'b1;
    CLR_REQ = 1'b1; CLR_MASK = 8'h02;
    exp_isel[1] = 1'b0;
    exp_fix[1]  = 1'b1;
    tick();
    CFG_WE = 1'b0; CLR_REQ = 1'b0;
    check("sim_isel", 32'(ISEL_O), 32'(exp_isel));
    check("sim_fix", 32'(FIXHOLD_O), 32'(exp_fix));
    check("sim_state", 32'(DBG_STATE), 32'(ST_QUIESCE));
    tick();
    check("sim_qrt", 32'(QRT_O), 'h02);
    CFG_WE = 1'b1; CFG_ADDR = 5'd2; CFG_ISEL = 1'b0; CFG_FIXHOLD = 1'b1;
    tick();
    check("drop_isel", 32'(ISEL_O), 32'(exp_isel));
    check("drop_fix", 32'(FIXHOLD_O), 32'(exp_fix));
    CFG_ADDR = 5'd9;
    tick();
    CFG_WE = 1'b0;
    check("drop_err", 32'(CFG_ERR), 0);
    wait_done(10, edges);
    check("sim_done_edges", 32'(edges), 3);

    // Mid-clear asynchronous reset
    tick();
    CLR_REQ = 1'b1; CLR_MASK = 8'h0F;
    tick();
    CLR_REQ = 1'b0;
    tick();
    tick();
    check("mid_qrt", 32'(QRT_O), 'h0F);
    #2;
    QRT_N = 1'b0;
    #1;
    check("mid_rst_qrt", 32'(QRT_O), 'hFF);
    check("mid_rst_isel", 32'(ISEL_O), 'hFF);
    check("mid_rst_fix", 32'(FIXHOLD_O), 'h00);
    check("mid_rst_capt", 32'(CAPT_EN), 0);
    check("mid_rst_rdy", 32'(CFG_RDY), 0);
    check("mid_rst_rd_data", 32'(RD_DATA), 0);
    check("mid_rst_state", 32'(DBG_STATE), 32'(ST_CLEAR));
    tick();
    QRT_N = 1'b1;
    wait_done(10, edges);
    check("mid_por_edges", 32'(edges), 5);
    check("mid_por_capt", 32'(CAPT_EN), 1);
    check("mid_por_isel", 32'(ISEL_O), 'hFF);

    tick();
    check("rd_queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
